// File: rtl/icache_pkg.sv
// Shared types and derived widths for the instruction-cache lookup controller.
package icache_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned INDEX_WIDTH    = 8;
  localparam int unsigned OFFSET_WIDTH   = 4;
  localparam int unsigned TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  // Stored tag word: valid bit on top of the address tag.
  localparam int unsigned TAG_SIZE       = TAG_WIDTH + 1;
  localparam int unsigned WORD_OFF_WIDTH = OFFSET_WIDTH - 2;
  localparam int unsigned WORDS_PER_LINE = 1 << WORD_OFF_WIDTH;
  localparam int unsigned NUM_LINES      = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {
    StFlush,
    StIdle,
    StCompare,
    StRefillReq,
    StRefillWait,
    StTagWrite,
    StRelookup
  } state_e;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] offset;
  } addr_t;

  function automatic addr_t split_addr(input logic [ADDR_WIDTH-1:0] addr);
    return addr_t'(addr);
  endfunction

endpackage

// File: rtl/icache_lookup_controller_if.sv
// CPU fetch, tag memory, memory bus and data memory signals of the lookup controller.
interface icache_lookup_controller_if;
  import icache_pkg::*;

  // CPU side
  logic                      fetch_i;
  logic [ADDR_WIDTH-1:0]     fetch_address_i;
  logic                      invalidate_i;
  logic                      stall_o;
  logic                      hit_o;
  // Tag memory port
  logic [INDEX_WIDTH-1:0]    tag_index_o;
  logic                      tag_read_o;
  logic                      tag_write_o;
  logic [TAG_SIZE-1:0]       tag_write_data_o;
  logic [TAG_SIZE-1:0]       tag_read_data_i;
  // Memory bus
  logic                      mem_request_o;
  logic [ADDR_WIDTH-1:0]     mem_address_o;
  logic                      mem_valid_i;
  logic [31:0]               mem_word_i;
  // Data memory write port
  logic                      data_write_o;
  logic [INDEX_WIDTH-1:0]    data_write_index_o;
  logic [WORD_OFF_WIDTH-1:0] data_write_offset_o;
  logic [31:0]               data_write_word_o;

  modport master (
    input  fetch_i, fetch_address_i, invalidate_i, tag_read_data_i, mem_valid_i, mem_word_i,
    output stall_o, hit_o, tag_index_o, tag_read_o, tag_write_o, tag_write_data_o,
           mem_request_o, mem_address_o, data_write_o, data_write_index_o,
           data_write_offset_o, data_write_word_o
  );

  modport slave (
    output fetch_i, fetch_address_i, invalidate_i, tag_read_data_i, mem_valid_i, mem_word_i,
    input  stall_o, hit_o, tag_index_o, tag_read_o, tag_write_o, tag_write_data_o,
           mem_request_o, mem_address_o, data_write_o, data_write_index_o,
           data_write_offset_o, data_write_word_o
  );

endinterface

// File: rtl/icache_lookup_controller.sv
// Direct-mapped instruction cache lookup: tag compare, miss refill and invalidation sweep.
module icache_lookup_controller import icache_pkg::*; (
  input logic                        clk_i,
  input logic                        rst_i,
  icache_lookup_controller_if.master bus
);

  state_e                    state_q;
  logic [INDEX_WIDTH-1:0]    sweep_q;
  logic [WORD_OFF_WIDTH-1:0] word_q;
  logic                      pend_inv_q;
  logic [TAG_WIDTH-1:0]      tag_q;
  logic [INDEX_WIDTH-1:0]    index_q;

  addr_t fetch_split;
  logic  tag_match;
  logic  refill_busy;
  logic  unused_offset;

  assign fetch_split   = split_addr(bus.fetch_address_i);
  // The byte offset never matters: lines are fetched and tagged whole.
  assign unused_offset = ^fetch_split.offset;

  assign tag_match = bus.tag_read_data_i[TAG_SIZE-1] &&
                     (bus.tag_read_data_i[TAG_WIDTH-1:0] == tag_q);

  // A miss has been committed to; invalidates arriving now are deferred until the refill ends.
  assign refill_busy = (state_q == StRefillReq) || (state_q == StRefillWait) ||
                       (state_q == StTagWrite)  || (state_q == StRelookup)   ||
                       ((state_q == StCompare) && !tag_match);

  // State, sweep/word counters, pending invalidate and captured fetch address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StFlush;
      sweep_q    <= '0;
      word_q     <= '0;
      pend_inv_q <= 1'b0;
      tag_q      <= '0;
      index_q    <= '0;
    end else begin
      if (bus.invalidate_i && refill_busy) begin
        pend_inv_q <= 1'b1;
      end
      case (state_q)
        StFlush: begin
          // Counter wraps back to zero, ready for the next sweep.
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == '1) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (bus.invalidate_i) begin
            state_q <= StFlush;
          end else if (bus.fetch_i) begin
            tag_q   <= fetch_split.tag;
            index_q <= fetch_split.index;
            state_q <= StCompare;
          end
        end
        StCompare: begin
          if (tag_match) begin
            if (bus.invalidate_i || pend_inv_q) begin
              pend_inv_q <= 1'b0;
              state_q    <= StFlush;
            end else if (bus.fetch_i) begin
              tag_q   <= fetch_split.tag;
              index_q <= fetch_split.index;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            state_q <= StRefillReq;
          end
        end
        StRefillReq: state_q <= StRefillWait;
        StRefillWait: begin
          if (bus.mem_valid_i) begin
            word_q <= word_q + 1'b1;
            if (word_q == '1) begin
              state_q <= StTagWrite;
            end
          end
        end
        StTagWrite: state_q <= StRelookup;
        StRelookup: state_q <= StCompare;
        default:    state_q <= StFlush;
      endcase
    end
  end

  // Output decode from state and same-cycle inputs; everything is forced low during reset.
  always_comb begin
    bus.stall_o             = 1'b0;
    bus.hit_o               = 1'b0;
    bus.tag_index_o         = '0;
    bus.tag_read_o          = 1'b0;
    bus.tag_write_o         = 1'b0;
    bus.tag_write_data_o    = '0;
    bus.mem_request_o       = 1'b0;
    bus.mem_address_o       = '0;
    bus.data_write_o        = 1'b0;
    bus.data_write_index_o  = '0;
    bus.data_write_offset_o = '0;
    bus.data_write_word_o   = rst_i ? 32'h0 : bus.mem_word_i;
    if (!rst_i) begin
      case (state_q)
        StFlush: begin
          bus.stall_o     = 1'b1;
          bus.tag_write_o = 1'b1;
          bus.tag_index_o = sweep_q;
        end
        StIdle: begin
          if (!bus.invalidate_i && bus.fetch_i) begin
            bus.tag_read_o  = 1'b1;
            bus.tag_index_o = fetch_split.index;
          end
        end
        StCompare: begin
          if (tag_match) begin
            bus.hit_o = 1'b1;
            if (!bus.invalidate_i && !pend_inv_q && bus.fetch_i) begin
              bus.tag_read_o  = 1'b1;
              bus.tag_index_o = fetch_split.index;
            end
          end else begin
            bus.stall_o = 1'b1;
          end
        end
        StRefillReq: begin
          bus.stall_o       = 1'b1;
          bus.mem_request_o = 1'b1;
          bus.mem_address_o = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
        end
        StRefillWait: begin
          bus.stall_o = 1'b1;
          if (bus.mem_valid_i) begin
            bus.data_write_o        = 1'b1;
            bus.data_write_index_o  = index_q;
            bus.data_write_offset_o = word_q;
          end
        end
        StTagWrite: begin
          bus.stall_o          = 1'b1;
          bus.tag_write_o      = 1'b1;
          bus.tag_index_o      = index_q;
          bus.tag_write_data_o = {1'b1, tag_q};
        end
        StRelookup: begin
          bus.stall_o     = 1'b1;
          bus.tag_read_o  = 1'b1;
          bus.tag_index_o = index_q;
        end
        default: bus.stall_o = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_lookup_controller.sv
// Self-checking bench: tag memory model, bus stimulus and a data-write scoreboard.
module tb_icache_lookup_controller;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  icache_lookup_controller_if bus();

  icache_lookup_controller dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  idx;
    logic [1:0]  off;
    logic [31:0] word;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_w;

  // Tag memory: one-cycle synchronous read, seeded with valid garbage so the sweep matters.
  logic [TAG_SIZE-1:0] tag_mem [NUM_LINES];
  bit seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < NUM_LINES; i++) tag_mem[i] <= {1'b1, TAG_WIDTH'($urandom)};
      tag_mem[8'h23] <= {1'b1, 20'h00001};
      seeded <= 1'b1;
    end else begin
      if (bus.tag_write_o) tag_mem[bus.tag_index_o] <= bus.tag_write_data_o;
      if (bus.tag_read_o) bus.tag_read_data_i <= tag_mem[bus.tag_index_o];
    end
  end

  // Data-write scoreboard and tag port exclusivity monitor.
  always @(negedge clk) begin
    #2;
    checks++;
    if (bus.tag_read_o === 1'b1 && bus.tag_write_o === 1'b1) begin
      failures++;
      $display("FAIL tag_rw_exclusive: read=1 write=1, required at most one");
    end
    if (bus.data_write_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL data_write_unexpected: idx=%h off=%0d word=%h, required no write",
                 bus.data_write_index_o, bus.data_write_offset_o, bus.data_write_word_o);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.data_write_index_o !== exp_w.idx || bus.data_write_offset_o !== exp_w.off ||
            bus.data_write_word_o !== exp_w.word) begin
          failures++;
          $display("FAIL data_write: idx=%h off=%0d word=%h, required idx=%h off=%0d word=%h",
                   bus.data_write_index_o, bus.data_write_offset_o, bus.data_write_word_o,
                   exp_w.idx, exp_w.off, exp_w.word);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Counts consecutive stall cycles from the current one and how many deviate from a sweep.
  task automatic measure_flush(output int n, output int bad);
    n = 0;
    bad = 0;
    while (n < 300 && bus.stall_o === 1'b1) begin
      if (bus.tag_write_o !== 1'b1 || bus.tag_read_o !== 1'b0 ||
          bus.tag_index_o !== INDEX_WIDTH'(n) || bus.tag_write_data_o !== '0) bad++;
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run_miss_refill(input logic [31:0] addr, input logic [31:0] wbase,
                                 input int inv_word, input int lat);
    logic [7:0]  idx;
    logic [19:0] tag;
    wr_t         w;
    idx = addr[11:4];
    tag = addr[31:12];
    @(negedge clk);
    bus.fetch_i = 1'b1;
    bus.fetch_address_i = addr;
    #1;
    checks++;
    if (bus.tag_read_o !== 1'b1 || bus.tag_index_o !== idx || bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL fetch_issue: read=%b index=%h stall=%b, required read=1 index=%h stall=0",
               bus.tag_read_o, bus.tag_index_o, bus.stall_o, idx);
    end
    @(negedge clk);
    bus.fetch_i = 1'b0;
    #1;
    checks++;
    if (bus.hit_o !== 1'b0 || bus.stall_o !== 1'b1) begin
      failures++;
      $display("FAIL miss_detect: hit=%b stall=%b, required hit=0 stall=1", bus.hit_o,
               bus.stall_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_request_o !== 1'b1 || bus.mem_address_o !== {addr[31:4], 4'h0}) begin
      failures++;
      $display("FAIL refill_request: req=%b addr=%h, required req=1 addr=%h",
               bus.mem_request_o, bus.mem_address_o, {addr[31:4], 4'h0});
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_request_o !== 1'b0 || bus.stall_o !== 1'b1) begin
      failures++;
      $display("FAIL request_pulse: req=%b stall=%b, required req=0 stall=1",
               bus.mem_request_o, bus.stall_o);
    end
    repeat (lat) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_valid_i  = 1'b1;
      bus.mem_word_i   = wbase + 32'(i);
      bus.invalidate_i = (i == inv_word);
      w.idx  = idx;
      w.off  = 2'(i);
      w.word = wbase + 32'(i);
      exp_q.push_back(w);
    end
    @(negedge clk);
    bus.mem_valid_i  = 1'b0;
    bus.invalidate_i = 1'b0;
    #1;
    checks++;
    if (bus.tag_write_o !== 1'b1 || bus.tag_index_o !== idx ||
        bus.tag_write_data_o !== {1'b1, tag} || bus.stall_o !== 1'b1) begin
      failures++;
      $display("FAIL tag_write: we=%b index=%h data=%h, required we=1 index=%h data=%h",
               bus.tag_write_o, bus.tag_index_o, bus.tag_write_data_o, idx, {1'b1, tag});
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.tag_read_o !== 1'b1 || bus.tag_write_o !== 1'b0 || bus.tag_index_o !== idx) begin
      failures++;
      $display("FAIL relookup: re=%b we=%b index=%h, required re=1 we=0 index=%h",
               bus.tag_read_o, bus.tag_write_o, bus.tag_index_o, idx);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.hit_o !== 1'b1 || bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL refill_hit: hit=%b stall=%b, required hit=1 stall=0", bus.hit_o,
               bus.stall_o);
    end
  endtask

  task automatic test_reset();
    int n, bad;
    rst_i = 1'b1;
    bus.fetch_i = 1'b0;
    bus.fetch_address_i = '0;
    bus.invalidate_i = 1'b0;
    bus.mem_valid_i = 1'b0;
    bus.mem_word_i = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.stall_o, bus.hit_o, bus.tag_read_o, bus.tag_write_o, bus.mem_request_o,
         bus.data_write_o} !== 6'b0 || bus.tag_index_o !== '0 || bus.mem_address_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs: stall=%b hit=%b re=%b we=%b req=%b dw=%b, required all 0",
               bus.stall_o, bus.hit_o, bus.tag_read_o, bus.tag_write_o, bus.mem_request_o,
               bus.data_write_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    measure_flush(n, bad);
    checks++;
    if (n !== 256) begin
      failures++;
      $display("FAIL flush_length: cycles=%0d, required 256", n);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL flush_pattern: bad_cycles=%0d, required 0", bad);
    end
  endtask

  task automatic test_miss();
    run_miss_refill(32'h0000_1230, 32'hA0, -1, 1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [3];
    seq = '{32'h0000_1234, 32'h0000_1238, 32'h0};
    @(negedge clk);
    bus.fetch_i = 1'b1;
    bus.fetch_address_i = 32'h0000_1230;
    #1;
    checks++;
    if (bus.tag_read_o !== 1'b1 || bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_issue: re=%b stall=%b, required re=1 stall=0", bus.tag_read_o,
               bus.stall_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.fetch_i = (i < 2);
      bus.fetch_address_i = seq[i];
      #1;
      checks++;
      if (bus.hit_o !== 1'b1 || bus.stall_o !== 1'b0 || bus.tag_read_o !== (i < 2)) begin
        failures++;
        $display("FAIL b2b_hit%0d: hit=%b stall=%b re=%b, required hit=1 stall=0 re=%b", i,
                 bus.hit_o, bus.stall_o, bus.tag_read_o, (i < 2));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.hit_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: hit=%b stall=%b, required hit=0 stall=0", bus.hit_o,
               bus.stall_o);
    end
  endtask

  task automatic test_conflict();
    run_miss_refill(32'h0000_2230, 32'hB0, -1, 0);
    // Line 0x23 now holds tag 2, so the original address must miss again.
    run_miss_refill(32'h0000_1230, 32'hC0, -1, 2);
  endtask

  task automatic test_idle_invalidate();
    int n, bad;
    @(negedge clk);
    bus.invalidate_i = 1'b1;
    bus.fetch_i = 1'b1;
    bus.fetch_address_i = 32'h0000_1230;
    #1;
    checks++;
    if (bus.tag_read_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL inv_priority: re=%b stall=%b, required re=0 stall=0", bus.tag_read_o,
               bus.stall_o);
    end
    @(negedge clk);
    bus.invalidate_i = 1'b0;
    bus.fetch_i = 1'b0;
    #1;
    measure_flush(n, bad);
    checks++;
    if (n !== 256 || bad !== 0) begin
      failures++;
      $display("FAIL idle_inv_flush: cycles=%0d bad=%0d, required 256 and 0", n, bad);
    end
  endtask

  task automatic test_invalidate_refill();
    int n, bad;
    run_miss_refill(32'h0000_1230, 32'hD0, 2, 1);
    @(negedge clk);
    #1;
    measure_flush(n, bad);
    checks++;
    if (n !== 256 || bad !== 0) begin
      failures++;
      $display("FAIL pending_inv_flush: cycles=%0d bad=%0d, required 256 and 0", n, bad);
    end
    run_miss_refill(32'h0000_1230, 32'hE0, -1, 2);
  endtask

  task automatic test_reset_mid_refill();
    int n, bad, stray;
    wr_t w;
    @(negedge clk);
    bus.fetch_i = 1'b1;
    bus.fetch_address_i = 32'h0000_3340;
    @(negedge clk);
    bus.fetch_i = 1'b0;
    #1;
    checks++;
    if (bus.hit_o !== 1'b0 || bus.stall_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_miss: hit=%b stall=%b, required hit=0 stall=1", bus.hit_o,
               bus.stall_o);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.mem_valid_i = 1'b1;
      bus.mem_word_i  = 32'h50 + 32'(i);
      w.idx = 8'h34;
      w.off = 2'(i);
      w.word = 32'h50 + 32'(i);
      exp_q.push_back(w);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst_i = 1'b1;
      bus.mem_word_i = 32'hBAD0 + 32'(i);
      #1;
      checks++;
      if ({bus.stall_o, bus.hit_o, bus.tag_read_o, bus.tag_write_o, bus.mem_request_o,
           bus.data_write_o} !== 6'b0) begin
        failures++;
        $display("FAIL mid_reset_outputs%0d: stall=%b re=%b we=%b dw=%b, required all 0", i,
                 bus.stall_o, bus.tag_read_o, bus.tag_write_o, bus.data_write_o);
      end
    end
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    measure_flush(n, bad);
    checks++;
    if (n !== 256 || bad !== 0) begin
      failures++;
      $display("FAIL mid_reset_flush: cycles=%0d bad=%0d, required 256 and 0", n, bad);
    end
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.data_write_o !== 1'b0) stray++;
      @(negedge clk);
      #1;
    end
    bus.mem_valid_i = 1'b0;
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL stray_valid: writes=%0d, required 0", stray);
    end
    run_miss_refill(32'h0000_3340, 32'hF0, -1, 1);
  endtask

  initial begin
    test_reset();
    test_miss();
    test_back_to_back();
    test_conflict();
    test_idle_invalidate();
    test_invalidate_refill();
    test_reset_mid_refill();
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_lookup_controller.md
Name: icache_lookup_controller

Overview:
- Control stage directly upstream of the cache tag memory for a direct-mapped, read-only (instruction) cache.
- Drives the tag memory read/write port, compares the returned tag one cycle later and signals hit or miss.
- On a miss, runs a refill FSM: fetches a block from the memory bus, streams words into the data memory, then writes the new tag.
- Also performs a full cache invalidation sweep after reset and on request.

Parameters:
ADDR_WIDTH, 32, CPU/bus byte address width
INDEX_WIDTH, 8, cache index bits (2**INDEX_WIDTH lines); drives tag memory address width
OFFSET_WIDTH, 4, byte offset within a line (16-byte line = 4 x 32-bit words)
TAG_SIZE, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH+1, stored tag word width: MSB is the valid bit, remaining bits are the address tag

Ports:
clk_i  in  1  clock; all logic is rising-edge
rst_i  in  1  synchronous, active-high reset
fetch_i  in  1  CPU fetch request, sampled only when stall_o=0
fetch_address_i  in  ADDR_WIDTH  fetch byte address
invalidate_i  in  1  one-cycle pulse requesting a full invalidation
stall_o  out  1  controller busy; CPU must hold its request
hit_o  out  1  fetch hit; the data memory output is valid this cycle
tag_index_o  out  INDEX_WIDTH  tag memory read/write address
tag_read_o  out  1  tag memory read enable
tag_write_o  out  1  tag memory write enable
tag_write_data_o  out  TAG_SIZE  {valid, tag} to write
tag_read_data_i  in  TAG_SIZE  tag returned by the tag memory (1-cycle synchronous read)
mem_request_o  out  1  one-cycle pulse starting a block read
mem_address_o  out  ADDR_WIDTH  line-aligned block address (offset bits = 0)
mem_valid_i  in  1  a bus word is valid this cycle
mem_word_i  in  32  bus data word
data_write_o  out  1  data memory write enable
data_write_index_o  out  INDEX_WIDTH  line index being refilled
data_write_offset_o  out  OFFSET_WIDTH-2  word offset within the line
data_write_word_o  out  32  word to write (mem_word_i, passed through combinationally)

Behaviour:
- Reset:
  - All outputs are 0.
  - State=FLUSH, sweep counter=0, pending-invalidate=0, captured address=0.
- FLUSH:
  - Each cycle: tag_write_o=1, tag_index_o=counter, tag_write_data_o=0, stall_o=1.
  - Counter increments each cycle. After index 2**INDEX_WIDTH-1 is written -> IDLE.
  - Sweep takes exactly 2**INDEX_WIDTH cycles.
- IDLE:
  - stall_o=0.
  - If invalidate_i: -> FLUSH. Invalidate has priority over a simultaneous fetch_i, which is ignored and must be re-presented.
  - Else if fetch_i: tag_read_o=1, tag_index_o=address index, capture the address -> COMPARE.
- COMPARE (one cycle after the read):
  - Hit = tag_read_data_i MSB=1 and its tag bits equal the captured tag.
  - On hit: hit_o=1 in this cycle, stall_o=0.
    - A new fetch_i in this cycle is accepted back-to-back (read issued, stay in COMPARE).
    - invalidate_i in this cycle -> FLUSH.
    - Otherwise -> IDLE.
  - On miss: hit_o=0, stall_o=1 -> REFILL_REQ.
- REFILL_REQ:
  - mem_request_o=1 for exactly one cycle, with mem_address_o = captured address with offset bits cleared -> REFILL_WAIT.
- REFILL_WAIT:
  - Each mem_valid_i: data_write_o=1, data_write_index_o=captured index, data_write_offset_o=word counter; then the counter increments.
  - Counter wraps at 2**(OFFSET_WIDTH-2).
  - After the last word -> TAG_WRITE.
  - No timeout; the bus must eventually deliver all words.
- TAG_WRITE:
  - tag_write_o=1, tag_write_data_o={1, captured tag}, tag_index_o=captured index -> RELOOKUP.
- RELOOKUP:
  - tag_read_o=1 for the captured index -> COMPARE, which now hits.
  - Miss-to-hit latency = 4 + bus latency + words cycles.
- invalidate_i while in REFILL_REQ, REFILL_WAIT, TAG_WRITE or RELOOKUP:
  - Latched into pending-invalidate and the refill completes normally.
  - The next COMPARE hit is still reported; then -> FLUSH instead of IDLE, and pending is cleared.
- invalidate_i during FLUSH is ignored (the sweep is already running).
- mem_valid_i outside REFILL_WAIT is ignored.
- stall_o is 1 in every state except IDLE and a COMPARE hit.
- tag_read_o and tag_write_o are never both 1.
- rst_i mid-operation: immediate return to reset values and FLUSH. An in-flight bus transaction is abandoned.

Decomposition:
- Package icache_pkg:
  - State enum: FLUSH, IDLE, COMPARE, REFILL_REQ, REFILL_WAIT, TAG_WRITE, RELOOKUP.
  - Address-split struct {tag, index, offset}.
  - Localparams for the derived widths and WORDS_PER_LINE.
- No sub-module is needed: single module, FSM plus two counters (sweep, word).

Test Plan:
- Reset -> stall_o=1 for exactly 256 cycles with tag_write_o=1, indices 0..255, data 0; then stall_o=0.
- Fetch 0x0000_1230 after the flush -> miss:
  - mem_request_o pulses with mem_address_o=0x0000_1230.
  - 4 mem_valid_i words 0xA0..0xA3 -> data writes at index 0x23, offsets 0..3.
  - Tag write {1,0x00001}; hit_o=1 on the RELOOKUP+1 cycle.
- Back-to-back fetches 0x1230, 0x1234, 0x1238 after the refill -> hit_o=1 on three consecutive cycles, stall_o=0 throughout.
- Conflict: fetch 0x0000_2230 after 0x0000_1230 -> miss; line 0x23 tag rewritten to 0x00002; a re-fetch of 0x1230 misses again.
- invalidate_i asserted during REFILL_WAIT word 2:
  - Refill completes and hit_o=1 is reported.
  - Then a 256-cycle FLUSH; the next fetch of the same address misses.
- rst_i asserted mid-refill after 2 words:
  - Outputs go to 0 the next cycle and FLUSH restarts.
  - Later stray mem_valid_i pulses cause no data_write_o.
